// File: rtl/axi_dma_nd_midend_2d.sv
// rtl/axi_dma_nd_midend_2d.sv - 2D descriptor sequencer issuing 1D bursts with in-order completion tracking
package axi_dma_nd_midend_2d_pkg;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned REP_W  = 16;

    typedef struct packed {
        logic [3:0]        id;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] num_bytes;
        logic [3:0]        cache_src;
        logic [3:0]        cache_dst;
        logic [1:0]        burst_src;
        logic [1:0]        burst_dst;
        logic [0:0]        user_dst;
        logic              decouple_rw;
        logic              deburst;
    } burst_req_t;

    typedef struct packed {
        burst_req_t        burst;
        logic [ADDR_W-1:0] src_stride;
        logic [ADDR_W-1:0] dst_stride;
        logic [REP_W-1:0]  reps;
    } nd_req_t;
endpackage

module axi_dma_nd_midend_2d #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned RepWidth       = 16,
    parameter int unsigned NumOutstanding = 4,
    parameter type burst_req_t = axi_dma_nd_midend_2d_pkg::burst_req_t,
    parameter type nd_req_t    = axi_dma_nd_midend_2d_pkg::nd_req_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  nd_req_t    nd_req_i,
    input  logic       nd_valid_i,
    output logic       nd_ready_o,
    output burst_req_t burst_req_o,
    output logic       burst_valid_o,
    input  logic       burst_ready_i,
    input  logic       burst_done_i,
    output logic       nd_done_o,
    output logic       busy_o
);
    localparam int unsigned PtrW = $clog2(NumOutstanding);
    localparam logic [PtrW:0] Depth = (PtrW+1)'(NumOutstanding);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state, state_d;
    burst_req_t            cur;
    logic [AddrWidth-1:0]  src_stride, dst_stride;
    logic [RepWidth-1:0]   rem;

    logic [NumOutstanding-1:0] flags;
    logic [PtrW-1:0]           wr_ptr, rd_ptr;
    logic [PtrW:0]             count;

    logic full, burst_hs, last_hs, nd_hs, load, push, pop;

    assign full        = (count == Depth);
    assign burst_req_o = cur;
    assign burst_hs    = burst_valid_o & burst_ready_i;
    assign last_hs     = burst_hs & (rem == RepWidth'(1));
    assign nd_hs       = nd_valid_i & nd_ready_o;
    assign load        = nd_hs & (nd_req_i.reps != '0);
    assign push        = burst_hs;
    // Completions with nothing outstanding are dropped rather than corrupting the pointers
    assign pop         = burst_done_i & (count != '0);
    assign nd_done_o   = pop & flags[rd_ptr];
    assign busy_o      = (state == ISSUE) | (count != '0);

    always_comb begin
        state_d       = state;
        burst_valid_o = 1'b0;
        nd_ready_o    = 1'b0;
        case (state)
            IDLE: begin
                nd_ready_o = 1'b1;
                if (load) state_d = ISSUE;
            end
            ISSUE: begin
                burst_valid_o = ~full;
                // Accepting on the final handshake lets the next transfer start without a bubble
                nd_ready_o    = (rem == RepWidth'(1)) & ~full & burst_ready_i;
                if (last_hs) state_d = load ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cur        <= '0;
            src_stride <= '0;
            dst_stride <= '0;
            rem        <= '0;
            flags      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                cur        <= nd_req_i.burst;
                src_stride <= nd_req_i.src_stride;
                dst_stride <= nd_req_i.dst_stride;
                rem        <= nd_req_i.reps;
            end else if (burst_hs) begin
                cur.src <= cur.src + src_stride;
                cur.dst <= cur.dst + dst_stride;
                rem     <= rem - RepWidth'(1);
            end
            if (push) begin
                flags[wr_ptr] <= (rem == RepWidth'(1));
                wr_ptr        <= wr_ptr + PtrW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PtrW'(1);
            if (push && !pop) count <= count + (PtrW+1)'(1);
            else if (pop && !push) count <= count - (PtrW+1)'(1);
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(burst_done_i && count == '0));

endmodule

// File: tb/tb_axi_dma_nd_midend_2d.sv
// tb/tb_axi_dma_nd_midend_2d.sv - randomized and directed bench for axi_dma_nd_midend_2d
module tb_axi_dma_nd_midend_2d;
    import axi_dma_nd_midend_2d_pkg::*;

    localparam int NO = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    nd_req_t    nd_req = '0;
    logic       nd_valid = 1'b0;
    logic       nd_ready;
    burst_req_t burst_req;
    logic       burst_valid;
    logic       burst_ready = 1'b0;
    logic       burst_done = 1'b0;
    logic       nd_done;
    logic       busy;

    always #5 clk = ~clk;

    axi_dma_nd_midend_2d #(.NumOutstanding(NO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .nd_req_i      (nd_req),
        .nd_valid_i    (nd_valid),
        .nd_ready_o    (nd_ready),
        .burst_req_o   (burst_req),
        .burst_valid_o (burst_valid),
        .burst_ready_i (burst_ready),
        .burst_done_i  (burst_done),
        .nd_done_o     (nd_done),
        .busy_o        (busy)
    );

    int passed = 0;
    int total  = 0;
    int ready_mode = 1;
    int done_mode  = 0;

    nd_req_t    pend_q[$];
    burst_req_t exp_q[$];
    bit         last_q[$];

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic nd_req_t mk_desc(logic [31:0] src, logic [31:0] dst, logic [31:0] nb,
                                        logic [31:0] ss, logic [31:0] ds, logic [15:0] reps);
        nd_req_t d;
        d.burst.id          = 4'($urandom);
        d.burst.src         = src;
        d.burst.dst         = dst;
        d.burst.num_bytes   = nb;
        d.burst.cache_src   = 4'($urandom);
        d.burst.cache_dst   = 4'($urandom);
        d.burst.burst_src   = 2'($urandom);
        d.burst.burst_dst   = 2'($urandom);
        d.burst.user_dst    = 1'($urandom);
        d.burst.decouple_rw = 1'($urandom);
        d.burst.deburst     = 1'($urandom);
        d.src_stride        = ss;
        d.dst_stride        = ds;
        d.reps              = reps;
        return d;
    endfunction

    // Expected 1D bursts: the i-th repetition sits at base + i*stride, modulo 2^32
    task automatic expand(nd_req_t d);
        burst_req_t b;
        for (int i = 0; i < int'(d.reps); i++) begin
            b     = d.burst;
            b.src = d.burst.src + 32'(i) * d.src_stride;
            b.dst = d.burst.dst + 32'(i) * d.dst_stride;
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        bit exp_valid, exp_ready, exp_done;
        nd_valid    = pend_q.size() > 0;
        nd_req      = nd_valid ? pend_q[0] : '0;
        burst_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
        burst_done  = (last_q.size() > 0) &&
                      ((done_mode == 2) ? ($urandom_range(0, 1) == 1) : (done_mode == 1));
        @(negedge clk);
        exp_valid = (exp_q.size() > 0) && (last_q.size() < NO);
        exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && exp_valid && burst_ready);
        exp_done  = 1'b0;
        if (burst_done) exp_done = last_q[0];
        chk("burst_valid", burst_valid, exp_valid);
        chk("nd_ready", nd_ready, exp_ready);
        chk("nd_done", nd_done, exp_done);
        chk("busy", busy, (exp_q.size() > 0) || (last_q.size() > 0));
        if (exp_valid) chk("burst_req", burst_req, exp_q[0]);
        if (burst_done) void'(last_q.pop_front());
        if (exp_valid && burst_ready) begin
            last_q.push_back(exp_q.size() == 1);
            void'(exp_q.pop_front());
        end
        if (nd_valid && exp_ready) expand(pend_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget && (pend_q.size() > 0 || exp_q.size() > 0 || last_q.size() > 0); i++)
            step();
        chk("drain", (pend_q.size() == 0 && exp_q.size() == 0 && last_q.size() == 0), 1'b1);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", burst_valid, 1'b0);
        chk("rst_nd_ready", nd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_nd_done", nd_done, 1'b0);
        chk("rst_req", burst_req, '0);
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Basic 2D transfer, completions after all issues
        ready_mode = 1; done_mode = 0;
        pend_q.push_back(mk_desc(32'h1000, 32'h8000, 32'd64, 32'h100, 32'h40, 16'd3));
        run(5);
        done_mode = 1;
        drain(50);

        // reps=0 discarded, then reps=1 back-to-back
        pend_q.push_back(mk_desc(32'h2000, 32'h3000, 32'd16, 32'h10, 32'h10, 16'd0));
        pend_q.push_back(mk_desc(32'h4000, 32'h5000, 32'd0, 32'h10, 32'h10, 16'd1));
        drain(50);

        // Backpressure in the middle of a transfer
        ready_mode = 1; done_mode = 1;
        pend_q.push_back(mk_desc(32'h6000, 32'h7000, 32'd32, 32'h80, 32'h20, 16'd4));
        run(3);
        ready_mode = 0;
        run(5);
        ready_mode = 1;
        drain(50);

        // Tracker full: completions withheld, then released one at a time
        done_mode = 0;
        pend_q.push_back(mk_desc(32'hA000, 32'hB000, 32'd8, 32'h8, 32'h8, 16'd6));
        run(8);
        done_mode = 1;
        run(1);
        done_mode = 0;
        run(3);
        done_mode = 1;
        drain(50);

        // Address wraparound and a negative destination stride
        pend_q.push_back(mk_desc(32'hFFFF_FFF0, 32'h100, 32'd4, 32'h20, 32'hFFFF_FFC0, 16'd2));
        drain(50);

        // Second descriptor taken on the final handshake of the first
        done_mode = 0;
        pend_q.push_back(mk_desc(32'hC000, 32'hD000, 32'd4, 32'h4, 32'h4, 16'd2));
        pend_q.push_back(mk_desc(32'hE000, 32'hF000, 32'd4, 32'h4, 32'h4, 16'd2));
        run(6);
        done_mode = 1;
        drain(50);

        // Reset in the middle of ISSUE drops everything
        done_mode = 0;
        pend_q.push_back(mk_desc(32'h1_0000, 32'h2_0000, 32'd4, 32'h4, 32'h4, 16'd5));
        run(3);
        nd_valid = 1'b0; burst_ready = 1'b0; burst_done = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", burst_valid, 1'b0);
        chk("midrst_nd_ready", nd_ready, 1'b1);
        chk("midrst_nd_done", nd_done, 1'b0);
        exp_q.delete();
        last_q.delete();
        @(posedge clk);
        #1 rst_ni = 1'b1;
        done_mode = 1;
        pend_q.push_back(mk_desc(32'h3_0000, 32'h4_0000, 32'd4, 32'h4, 32'h4, 16'd1));
        drain(50);

        // Randomized traffic
        ready_mode = 2; done_mode = 2;
        for (int i = 0; i < 40; i++)
            pend_q.push_back(mk_desc($urandom, $urandom, 32'($urandom_range(0, 256)),
                                     $urandom, $urandom, 16'($urandom_range(0, 5))));
        drain(3000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
